bfm_apbslave_mem: RTL and testbench
===================================

// Module: bfm_apbslave_mem
// PURPOSE
//  APB3 slave memory model; sits directly downstream of the AHB-to-APB bridge BFM on one PSEL slot.
//  Word-addressed RAM with programmable wait states and PSLVERR on out-of-range addresses.
//  Lets the bridge's PREADY-stall and error paths, including HRESP generation, be exercised in simulation.
// PARAMETERS
//  AWIDTH      10  word-address bits; depth = 2**AWIDTH 32-bit words
//  WAIT_STATES  0  access-phase cycles with PREADY low before completion (0..15)
//  TPD          1  output delay (ns) on all outputs
// PORTS
//  PCLK     in   1   clock; all logic rising-edge
//  PRESETN  in   1   asynchronous active-low reset
//  PSEL     in   1   slot select (one bit of bridge PSEL[15:0])
//  PADDR    in   32  byte address; [1:0] ignored, [AWIDTH+1:2] word index, [23:AWIDTH+2] range check
//  PWRITE   in   1   1=write, 0=read
//  PENABLE  in   1   access phase
//  PWDATA   in   32  write data
//  PRDATA   out  32  read data; valid only while PREADY=1 on a read
//  PREADY   out  1   transfer completion
//  PSLVERR  out  1   error response; valid only with PREADY=1
// BEHAVIOUR
//  Reset: PRDATA=0, PREADY=0, PSLVERR=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
//  FSM states: IDLE, ACCESS, DONE.
//   IDLE: on PSEL=1 & PENABLE=0 (setup), latch PADDR/PWRITE and evaluate the range check.
//    Load counter=WAIT_STATES, then go to ACCESS.
//    If WAIT_STATES=0, set PREADY=1 in that same edge, so it is high in the first PENABLE cycle.
//   ACCESS: while counter!=0, decrement and keep PREADY=0. At counter==1, register PREADY=1.
//    A transfer completes on the edge where PSEL & PENABLE & PREADY all =1.
//    At completion: PREADY->0, go to DONE.
//    A back-to-back setup seen in that same cycle is not possible (APB requires a setup cycle).
//   DONE: one cycle; return to IDLE. A setup in that cycle is accepted exactly as in IDLE.
//  Total latency: setup + (WAIT_STATES+1) access cycles.
//  Write: RAM[index] <= PWDATA at the completion edge, only if in range.
//  Read: PRDATA <= RAM[index] registered together with PREADY; PRDATA=0 when PREADY=0 or on error.
//  Range error: PADDR[23:AWIDTH+2]!=0 -> PSLVERR=1 with PREADY, write suppressed, PRDATA=0.
//   Error still observes the configured wait states.
//  PSEL dropped during ACCESS before completion (protocol violation): abort to IDLE.
//   PREADY/PSLVERR->0, no RAM write, $display warning.
//  PENABLE=1 while in IDLE: ignored, no transfer.
//  Reset asserted mid-transfer: outputs return to reset values immediately, any pending write is lost.
// CONFIGURATION
//  APBSLV_RANDWAIT_EN defined: counter load = WAIT_STATES + (lfsr[1:0]), i.e. WAIT_STATES..WAIT_STATES+3.
//   lfsr is 16-bit, x^16+x^14+x^13+x^11, seed 16'hACE1 at reset, advances once per accepted setup.
//  Undefined: counter load = WAIT_STATES exactly; no LFSR logic present.
// STRUCTURE
//  bfm_apbslave_defs.v (`include): FSM state encodings (2-bit), LFSR seed/taps, WAIT_STATES max.
//  One sub-module bfm_apbslave_lfsr (16-bit Galois LFSR, enable input), instantiated only under APBSLV_RANDWAIT_EN.
//  RAM is an inline reg array.
// TESTING
//  1 WAIT_STATES=0: write 0xDEADBEEF @0x004, read @0x004.
//    -> PREADY=1 in first PENABLE cycle of each; PRDATA=0xDEADBEEF, PSLVERR=0.
//  2 WAIT_STATES=3: read @0x010.
//    -> PREADY low 3 access cycles, high 4th; bridge HREADYOUT stalls accordingly.
//  3 AWIDTH=10: write 0x12345678 @0x1000 (out of range).
//    -> PSLVERR=1 with PREADY, PRDATA=0; later read @0x000 unaffected.
//  4 PSEL deasserted in 2nd access cycle of a write @0x008 (WAIT_STATES=3).
//    -> FSM IDLE, RAM[2] unchanged, warning printed.
//  5 PRESETN pulsed low during ACCESS of write @0x00C.
//    -> PREADY/PSLVERR/PRDATA=0 immediately; RAM[3] unchanged; next transfer completes normally.
//  6 APBSLV_RANDWAIT_EN, WAIT_STATES=1, 64 reads.
//    -> every stall within 1..4 cycles, all four values seen, data correct.

Source files
------------

// File: rtl/bfm_apbslave_mem_pkg.sv
// ---------------------------------------------------------------------------
// bfm_apbslave_mem_pkg
//   Shared definitions for the APB3 slave memory model: FSM state encoding,
//   wait-counter sizing, LFSR seed/taps and small helper functions.
//   Optional feature macro used by the files of this slice: APBSLV_RANDWAIT_EN.
// ---------------------------------------------------------------------------
package bfm_apbslave_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    localparam int WAIT_MAX = 15;
    // Counter must hold WAIT_MAX plus the largest random extension (3).
    localparam int CNT_W    = 5;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois form of x^16 + x^14 + x^13 + x^11, shifting right.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Address is in range when every bit between the word index and bit 23 is zero.
    function automatic logic addr_in_range(input logic [31:0] paddr, input int unsigned awidth);
        logic [23:0] hi;
        hi = paddr[23:0] >> (awidth + 2);
        return (hi == '0);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/bfm_apbslave_mem_lfsr.sv
// ---------------------------------------------------------------------------
// bfm_apbslave_lfsr
//   16-bit Galois LFSR supplying the random wait-state extension.
//   Present only when APBSLV_RANDWAIT_EN is defined; otherwise this file is
//   empty and no LFSR logic exists.
// Ports:
//   PCLK     in   clock, rising edge
//   PRESETN  in   asynchronous active-low reset (state reloads seed)
//   en       in   advance one step on this edge
//   rnd      out  low two bits of the current LFSR state
// ---------------------------------------------------------------------------
`ifdef APBSLV_RANDWAIT_EN
module bfm_apbslave_lfsr
    import bfm_apbslave_mem_pkg::*;
(
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       en,
    output logic [1:0] rnd
);

    logic [15:0] lfsr_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            lfsr_q <= LFSR_SEED;
        end else if (en) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign rnd = lfsr_q[1:0];

endmodule
`endif

// File: rtl/bfm_apbslave_mem.sv
// ---------------------------------------------------------------------------
// bfm_apbslave_mem
//   APB3 slave memory model: word-addressed RAM with programmable wait states
//   and PSLVERR on out-of-range addresses.
//   Optional feature: APBSLV_RANDWAIT_EN adds 0..3 random wait states per
//   transfer from a 16-bit LFSR.
// Parameters:
//   AWIDTH       word-address bits, depth = 2**AWIDTH 32-bit words
//   WAIT_STATES  access cycles with PREADY low before completion (0..15)
//   TPD          output delay in ns (simulation notion only; registered
//                outputs carry no modelled delay)
// Ports:
//   PCLK     in   clock, rising edge
//   PRESETN  in   asynchronous active-low reset
//   PSEL     in   slot select
//   PADDR    in   byte address; [AWIDTH+1:2] index, [23:AWIDTH+2] range check
//   PWRITE   in   1 = write
//   PENABLE  in   access phase
//   PWDATA   in   write data
//   PRDATA   out  read data, valid with PREADY on a read, else 0
//   PREADY   out  transfer completion
//   PSLVERR  out  error response, valid with PREADY
// ---------------------------------------------------------------------------
module bfm_apbslave_mem
    import bfm_apbslave_mem_pkg::*;
#(
    parameter int AWIDTH      = 10,
    parameter int WAIT_STATES = 0,
    parameter int TPD         = 1
)
(
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int DEPTH = 2 ** AWIDTH;

    if (WAIT_STATES < 0 || WAIT_STATES > WAIT_MAX || TPD < 0 || AWIDTH < 1 || AWIDTH > 21) begin : g_bad_param
        $error("bfm_apbslave_mem: parameter out of range");
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [AWIDTH-1:0]   idx_q, idx_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic                ready_d, slverr_d;
    logic [31:0]         rdata_d;
    logic                mem_we;
    logic                abort;

    logic [31:0]         mem [DEPTH];

    logic                setup;
    logic [AWIDTH-1:0]   setup_idx;
    logic                setup_ok;
    logic [CNT_W-1:0]    wait_load;
    logic                unused_addr_bits;

    // A setup is only recognised outside the access phase; PENABLE high here
    // without a prior setup is ignored.
    assign setup     = PSEL && !PENABLE && (state_q != ST_ACCESS);
    assign setup_idx = PADDR[AWIDTH+1:2];
    assign setup_ok  = addr_in_range(PADDR, AWIDTH);
    assign unused_addr_bits = ^{PADDR[31:24], PADDR[1:0]};

`ifdef APBSLV_RANDWAIT_EN
    logic [1:0] rnd;

    bfm_apbslave_lfsr u_lfsr (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .en      (setup),
        .rnd     (rnd)
    );

    assign wait_load = CNT_W'(WAIT_STATES) + CNT_W'(rnd);
`else
    assign wait_load = CNT_W'(WAIT_STATES);
`endif

    // Next-state and registered-output logic.  PREADY/PSLVERR/PRDATA are
    // computed here and registered together, so read data appears in the
    // same cycle PREADY rises.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        err_d    = err_q;
        ready_d  = PREADY;
        slverr_d = PSLVERR;
        rdata_d  = PRDATA;
        mem_we   = 1'b0;
        abort    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d  = ST_IDLE;
                ready_d  = 1'b0;
                slverr_d = 1'b0;
                rdata_d  = '0;
                if (setup) begin
                    state_d = ST_ACCESS;
                    idx_d   = setup_idx;
                    wr_d    = PWRITE;
                    err_d   = !setup_ok;
                    cnt_d   = wait_load;
                    // Zero wait: PREADY must already be high in the first PENABLE cycle.
                    if (wait_load == '0) begin
                        ready_d  = 1'b1;
                        slverr_d = !setup_ok;
                        rdata_d  = (!PWRITE && setup_ok) ? mem[setup_idx] : '0;
                    end
                end
            end

            ST_ACCESS: begin
                if (!PSEL) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    slverr_d = 1'b0;
                    rdata_d  = '0;
                    abort    = 1'b1;
                end else if (PENABLE && PREADY) begin
                    mem_we   = wr_q && !err_q;
                    state_d  = ST_DONE;
                    ready_d  = 1'b0;
                    slverr_d = 1'b0;
                    rdata_d  = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        ready_d  = 1'b1;
                        slverr_d = err_q;
                        rdata_d  = (!wr_q && !err_q) ? mem[idx_q] : '0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            PREADY  <= ready_d;
            PSLVERR <= slverr_d;
            PRDATA  <= rdata_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            mem[idx_q] <= PWDATA;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge PCLK) begin
        if (PRESETN && abort) begin
            $warning("bfm_apbslave_mem: PSEL dropped during access phase, transfer aborted");
        end
    end
`endif

endmodule

// File: tb/tb_bfm_apbslave_mem.sv
// ---------------------------------------------------------------------------
// tb_bfm_apbslave_mem
//   Directed bench for bfm_apbslave_mem.  Three instances with WAIT_STATES
//   0, 3 and 1 share one clock but have independent buses and resets.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bfm_apbslave_mem;

    localparam int WS [3] = '{0, 3, 1};

    logic        clk;
    logic        rstn    [3];
    logic        psel    [3];
    logic        pwrite  [3];
    logic        penable [3];
    logic [31:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int n_chk = 0;
    int n_err = 0;

`ifdef APBSLV_RANDWAIT_EN
    logic [15:0] m_lfsr [3];

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction
`endif

    bfm_apbslave_mem #(.AWIDTH(10), .WAIT_STATES(0), .TPD(1)) u_ws0 (
        .PCLK(clk), .PRESETN(rstn[0]), .PSEL(psel[0]), .PADDR(paddr[0]),
        .PWRITE(pwrite[0]), .PENABLE(penable[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    bfm_apbslave_mem #(.AWIDTH(10), .WAIT_STATES(3), .TPD(1)) u_ws3 (
        .PCLK(clk), .PRESETN(rstn[1]), .PSEL(psel[1]), .PADDR(paddr[1]),
        .PWRITE(pwrite[1]), .PENABLE(penable[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    bfm_apbslave_mem #(.AWIDTH(10), .WAIT_STATES(1), .TPD(1)) u_ws1 (
        .PCLK(clk), .PRESETN(rstn[2]), .PSEL(psel[2]), .PADDR(paddr[2]),
        .PWRITE(pwrite[2]), .PENABLE(penable[2]), .PWDATA(pwdata[2]),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // mode 0: normal transfer; 1: drop PSEL in 2nd access cycle;
    // 2: pulse reset while PREADY is high instead of completing.
    task automatic apb_xfer(input int s, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int mode, input string tag,
                            output logic [31:0] rdata, output logic err, output int stalls);
        int exp_load;
        exp_load = WS[s];
`ifdef APBSLV_RANDWAIT_EN
        exp_load = exp_load + int'(m_lfsr[s][1:0]);
        m_lfsr[s] = lfsr_step(m_lfsr[s]);
`endif
        rdata  = '0;
        err    = 1'b0;
        stalls = 0;
        @(posedge clk); #1;
        psel[s] = 1'b1; penable[s] = 1'b0; pwrite[s] = wr; paddr[s] = addr; pwdata[s] = wdata;
        @(posedge clk); #1;
        penable[s] = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (mode == 1 && cyc == 1) begin
                psel[s] = 1'b0; penable[s] = 1'b0; pwrite[s] = 1'b0;
                @(posedge clk); #1;
                chk({tag, "_abort_pready"}, 32'(pready[s]), 32'd0);
                return;
            end
            @(negedge clk);
            if (pready[s]) begin
                rdata = prdata[s];
                err   = pslverr[s];
                chk({tag, "_stall"}, 32'(stalls), 32'(exp_load));
                if (mode == 2) begin
                    #1 rstn[s] = 1'b0;
                    #1;
                    chk({tag, "_rst_pready"},  32'(pready[s]),  32'd0);
                    chk({tag, "_rst_pslverr"}, 32'(pslverr[s]), 32'd0);
                    chk({tag, "_rst_prdata"},  prdata[s],       32'd0);
                    psel[s] = 1'b0; penable[s] = 1'b0; pwrite[s] = 1'b0;
                    @(posedge clk); #1;
                    rstn[s] = 1'b1;
`ifdef APBSLV_RANDWAIT_EN
                    m_lfsr[s] = 16'hACE1;
`endif
                end else begin
                    @(posedge clk); #1;
                    psel[s] = 1'b0; penable[s] = 1'b0; pwrite[s] = 1'b0;
                end
                return;
            end
            stalls++;
            @(posedge clk); #1;
        end
        chk({tag, "_timeout"}, 32'd1, 32'd0);
        psel[s] = 1'b0; penable[s] = 1'b0; pwrite[s] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          st;
        logic [3:0]  seen;

        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0; psel[i] = 1'b0; pwrite[i] = 1'b0; penable[i] = 1'b0;
            paddr[i] = '0; pwdata[i] = '0;
`ifdef APBSLV_RANDWAIT_EN
            m_lfsr[i] = 16'hACE1;
`endif
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready0",  32'(pready[0]),  32'd0);
        chk("rst_pslverr0", 32'(pslverr[0]), 32'd0);
        chk("rst_prdata0",  prdata[0],       32'd0);
        chk("rst_pready3",  32'(pready[1]),  32'd0);
        for (int i = 0; i < 3; i++) rstn[i] = 1'b1;

        // PENABLE without setup in IDLE must not start a transfer
        @(posedge clk); #1;
        psel[0] = 1'b1; penable[0] = 1'b1;
        @(posedge clk); #1;
        chk("idle_penable_pready", 32'(pready[0]), 32'd0);
        psel[0] = 1'b0; penable[0] = 1'b0;

        // zero wait states
        apb_xfer(0, 1'b1, 32'h004, 32'hDEADBEEF, 0, "t1_wr", rd, er, st);
        chk("t1_wr_err", 32'(er), 32'd0);
        apb_xfer(0, 1'b0, 32'h004, 32'h0, 0, "t1_rd", rd, er, st);
        chk("t1_rd_data", rd, 32'hDEADBEEF);
        chk("t1_rd_err", 32'(er), 32'd0);

        // three wait states
        apb_xfer(1, 1'b1, 32'h010, 32'hCAFEF00D, 0, "t2_wr", rd, er, st);
        apb_xfer(1, 1'b0, 32'h010, 32'h0, 0, "t2_rd", rd, er, st);
        chk("t2_rd_data", rd, 32'hCAFEF00D);
        chk("t2_rd_err", 32'(er), 32'd0);

        // out-of-range: 0x1000 aliases index 0, so the write must be suppressed
        apb_xfer(0, 1'b1, 32'h000, 32'h11111111, 0, "t3_wr0", rd, er, st);
        apb_xfer(0, 1'b1, 32'h1000, 32'h12345678, 0, "t3_wr_oob", rd, er, st);
        chk("t3_wr_oob_err", 32'(er), 32'd1);
        apb_xfer(0, 1'b0, 32'h1000, 32'h0, 0, "t3_rd_oob", rd, er, st);
        chk("t3_rd_oob_err", 32'(er), 32'd1);
        chk("t3_rd_oob_data", rd, 32'h0);
        apb_xfer(0, 1'b0, 32'h000, 32'h0, 0, "t3_rd0", rd, er, st);
        chk("t3_rd0_data", rd, 32'h11111111);
        chk("t3_rd0_err", 32'(er), 32'd0);
        apb_xfer(1, 1'b0, 32'h2000, 32'h0, 0, "t3_rd_oob3", rd, er, st);
        chk("t3_rd_oob3_err", 32'(er), 32'd1);
        chk("t3_rd_oob3_data", rd, 32'h0);
        // top word of the in-range window; byte-lane bits ignored
        apb_xfer(0, 1'b1, 32'hFFC, 32'h0BADF00D, 0, "t3_wr_top", rd, er, st);
        apb_xfer(0, 1'b0, 32'hFFF, 32'h0, 0, "t3_rd_top", rd, er, st);
        chk("t3_rd_top_data", rd, 32'h0BADF00D);
        chk("t3_rd_top_err", 32'(er), 32'd0);

        // PSEL dropped in 2nd access cycle
        apb_xfer(1, 1'b1, 32'h008, 32'hA5A5A5A5, 0, "t4_wr", rd, er, st);
        apb_xfer(1, 1'b1, 32'h008, 32'h5A5A5A5A, 1, "t4_abort", rd, er, st);
        apb_xfer(1, 1'b0, 32'h008, 32'h0, 0, "t4_rd", rd, er, st);
        chk("t4_rd_data", rd, 32'hA5A5A5A5);

        // reset pulse while the write is about to complete
        apb_xfer(1, 1'b1, 32'h00C, 32'h0C0C0C0C, 0, "t5_wr", rd, er, st);
        apb_xfer(1, 1'b1, 32'h00C, 32'hFFFF0000, 2, "t5_rst", rd, er, st);
        apb_xfer(1, 1'b0, 32'h00C, 32'h0, 0, "t5_rd", rd, er, st);
        chk("t5_rd_data", rd, 32'h0C0C0C0C);

        // 64 reads on the one-wait-state instance
        for (int i = 0; i < 8; i++) begin
            apb_xfer(2, 1'b1, 32'(i * 4), 32'h5000_0000 + 32'(i * 32'h0101), 0, "t6_wr", rd, er, st);
        end
        seen = '0;
        for (int i = 0; i < 64; i++) begin
            apb_xfer(2, 1'b0, 32'((i % 8) * 4), 32'h0, 0, "t6_rd", rd, er, st);
            chk("t6_rd_data", rd, 32'h5000_0000 + 32'((i % 8) * 32'h0101));
            if (st >= 1 && st <= 4) seen[st-1] = 1'b1;
        end
`ifdef APBSLV_RANDWAIT_EN
        chk("t6_all_stalls_seen", 32'(seen), 32'hF);
`else
        chk("t6_stall_set", 32'(seen), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
